// File: rtl/pdm_cic_decim.sv
// pdm_cic_decim: N-stage CIC decimator turning a 1-bit PDM stream into signed PCM samples.
// Integrators run at the strobe rate; combs are driven by a token that ripples one stage per clock.
module pdm_cic_decim #(
  parameter int ORDER = 4,
  parameter int R     = 32,
  parameter int M     = 1,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             data_in,
  output logic [OUT_W-1:0] data_out,
  output logic             valid
);
  localparam int W_ACC = ORDER*$clog2(R*M)+2;
  localparam int CNT_W = $clog2(R);
  logic [W_ACC-1:0] integ [ORDER];
  logic [W_ACC-1:0] comb [ORDER];
  logic [W_ACC-1:0] comb_in [ORDER];
  logic [W_ACC-1:0] dly [ORDER][M];
  logic [W_ACC-1:0] x, cap, cap_next;
  logic [OUT_W-1:0] scaled;
  logic [CNT_W-1:0] cnt;
  logic [ORDER:0]   tok;
  logic             tick;
  assign x    = data_in ? W_ACC'(1) : '1;
  assign tick = we && cnt == CNT_W'(R-1);
  // cap sees the value the last integrator takes on this same edge
  if (ORDER == 1) begin : g_cap1
    assign cap_next = integ[0] + x;
  end else begin : g_capn
    assign cap_next = integ[ORDER-2] + integ[ORDER-1];
  end
  for (genvar k = 0; k < ORDER; k++) begin : g_in
    if (k == 0) begin : g_first
      assign comb_in[k] = cap;
    end else begin : g_rest
      assign comb_in[k] = comb[k-1];
    end
  end
  if (OUT_W < W_ACC) begin : g_trunc
    assign scaled = comb[ORDER-1][W_ACC-1 -: OUT_W];
  end else begin : g_sext
    assign scaled = OUT_W'($signed(comb[ORDER-1]));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ORDER; i++) begin
        integ[i] <= '0;
        comb[i]  <= '0;
        for (int j = 0; j < M; j++) dly[i][j] <= '0;
      end
      cnt      <= '0;
      cap      <= '0;
      tok      <= '0;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      if (we) begin
        integ[0] <= integ[0] + x;
        for (int i = 1; i < ORDER; i++) integ[i] <= integ[i] + integ[i-1];
        cnt <= tick ? '0 : cnt + 1'b1;
      end
      if (tick) cap <= cap_next;
      tok <= {tok[ORDER-1:0], tick};
      for (int k = 0; k < ORDER; k++) begin
        if (tok[k]) begin
          comb[k]   <= comb_in[k] - dly[k][M-1];
          dly[k][0] <= comb_in[k];
          for (int j = 1; j < M; j++) dly[k][j] <= dly[k][j-1];
        end
      end
      valid <= tok[ORDER];
      if (tok[ORDER]) data_out <= scaled;
    end
  end
endmodule

// File: tb/tb_pdm_cic_decim.sv
// tb_pdm_cic_decim: checks two CIC configurations against a convolution model of the filter.
// The model uses the closed-form impulse response (boxcar^ORDER) rather than the recurrences.
module tb_pdm_cic_decim;
  logic clk = 1'b0, rst = 1'b1;
  logic we_a = 1'b0, din_a = 1'b0, valid_a;
  logic [15:0] do_a;
  logic we_b = 1'b0, din_b = 1'b0, valid_b;
  logic [23:0] do_b;
  int checks = 0, errors = 0, cyc = 0, sa = 0, sb = 0;
  typedef struct {int due; longint val;} exp_t;
  exp_t qa[$], qb[$];
  exp_t e;
  longint got_a[$], got_b[$], run1[$];
  longint hold_a = 0, hold_b = 0;
  longint h[2][1024];
  int hlen[2];
  int hist[2][8192];
  bit rb[2048];
  bit ea, eb;

  always #5 clk = ~clk;

  pdm_cic_decim dut_a (.clk(clk), .rst(rst), .we(we_a), .data_in(din_a), .data_out(do_a), .valid(valid_a));
  pdm_cic_decim #(.ORDER(3), .R(2), .M(2), .OUT_W(24)) dut_b (
    .clk(clk), .rst(rst), .we(we_b), .data_in(din_b), .data_out(do_b), .valid(valid_b));

  task automatic cmp(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // impulse response of ORDER cascaded length-RM boxcars
  function automatic void build_h(input int idx, input int order, input int rm);
    longint t[1024];
    for (int n = 0; n < 1024; n++) h[idx][n] = 0;
    h[idx][0] = 1;
    hlen[idx] = 1;
    for (int o = 0; o < order; o++) begin
      for (int n = 0; n < hlen[idx] + rm - 1; n++) begin
        t[n] = 0;
        for (int j = 0; j < rm; j++)
          if (n - j >= 0 && n - j < hlen[idx]) t[n] += h[idx][n-j];
      end
      hlen[idx] += rm - 1;
      for (int n = 0; n < hlen[idx]; n++) h[idx][n] = t[n];
    end
  endfunction

  // output for the tick on strobe s; the integrator chain adds ORDER-1 strobes of delay
  function automatic longint model(input int idx, input int s, input int order, input int wacc, input int outw);
    longint acc = 0;
    for (int j = 0; j < hlen[idx]; j++) begin
      int k = s - (order - 1) - j;
      if (k >= 0) acc += h[idx][j] * hist[idx][k];
    end
    if (outw < wacc) acc = acc >>> (wacc - outw);
    return acc;
  endfunction

  always @(posedge rst) begin
    sa = 0; sb = 0; qa.delete(); qb.delete(); hold_a = 0; hold_b = 0;
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (we_a) begin
        hist[0][sa] = din_a ? 1 : -1;
        if (sa % 32 == 31) begin e.due = cyc + 5; e.val = model(0, sa, 4, 22, 16); qa.push_back(e); end
        sa++;
      end
      if (we_b) begin
        hist[1][sb] = din_b ? 1 : -1;
        if (sb % 2 == 1) begin e.due = cyc + 4; e.val = model(1, sb, 3, 8, 24); qb.push_back(e); end
        sb++;
      end
    end
    #1;
    ea = qa.size() > 0 && qa[0].due == cyc;
    if (ea) begin hold_a = qa[0].val; void'(qa.pop_front()); end
    cmp("a_valid", valid_a, ea);
    cmp("a_data", $signed(do_a), hold_a);
    if (valid_a) got_a.push_back(longint'($signed(do_a)));
    eb = qb.size() > 0 && qb[0].due == cyc;
    if (eb) begin hold_b = qb[0].val; void'(qb.pop_front()); end
    cmp("b_valid", valid_b, eb);
    cmp("b_data", $signed(do_b), hold_b);
    if (valid_b) got_b.push_back(longint'($signed(do_b)));
  end

  task automatic reset_dut;
    #3 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic first_latency(input string nm);
    int n = 0;
    we_a = 1'b1; din_a = 1'b1;
    do begin @(posedge clk); #2; n++; end while (!valid_a && n < 60);
    cmp(nm, n, 37);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int nv;
    build_h(0, 4, 32);
    build_h(1, 3, 4);
    #23;
    cmp("reset_a_data", do_a, 0);
    cmp("reset_a_valid", valid_a, 0);
    cmp("reset_b_data", do_b, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    first_latency("a_first_valid_edge");
    repeat (256) @(negedge clk);
    cmp("a_ones_steady", got_a[$], 16384);
    din_a = 1'b0;
    repeat (256) @(negedge clk);
    cmp("a_zeros_steady", got_a[$], -16384);
    for (int i = 0; i < 320; i++) begin din_a = i[0]; @(negedge clk); end
    cmp("a_alt_steady", got_a[$], 0);
    we_a = 1'b0;
    reset_dut();
    got_a.delete();
    for (int i = 0; i < 2048; i++) begin
      rb[i] = 1'($urandom_range(0, 1));
      we_a = 1'b1; din_a = rb[i];
      @(negedge clk);
    end
    we_a = 1'b0;
    repeat (10) @(negedge clk);
    cmp("a_cont_count", got_a.size(), 64);
    run1 = got_a;
    reset_dut();
    got_a.delete();
    for (int i = 0; i < 2048; i++) begin
      we_a = 1'b1; din_a = rb[i];
      @(negedge clk);
      we_a = 1'b0; din_a = 1'($urandom_range(0, 1));
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    cmp("a_stride_count", got_a.size(), 64);
    for (int i = 0; i < got_a.size() && i < run1.size(); i++) cmp("a_stride_vs_cont", got_a[i], run1[i]);
    reset_dut();
    got_a.delete();
    we_a = 1'b1; din_a = 1'b1;
    repeat (98) @(posedge clk);
    cmp("a_pre_rst_outputs", got_a.size(), 2);
    #3 rst = 1'b1;
    #1;
    cmp("a_async_rst_data", do_a, 0);
    cmp("a_async_rst_valid", valid_a, 0);
    we_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    cmp("a_no_aborted_valid", got_a.size(), 2);
    first_latency("a_post_rst_valid_edge");
    @(negedge clk);
    we_a = 1'b0;
    repeat (10) @(negedge clk);
    we_b = 1'b1; din_b = 1'b1;
    repeat (60) @(negedge clk);
    cmp("b_ones_steady", got_b[$], 64);
    nv = 0;
    repeat (40) begin @(posedge clk); #2; nv += int'(valid_b); end
    cmp("b_valid_every_2", nv, 20);
    @(negedge clk);
    din_b = 1'b0;
    repeat (60) @(negedge clk);
    cmp("b_zeros_steady", got_b[$], -64);
    for (int i = 0; i < 400; i++) begin din_b = 1'($urandom_range(0, 1)); @(negedge clk); end
    we_b = 1'b0;
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
